altmem_ctrl_68k: RTL and testbench
==================================

Name: altmem_ctrl_68k

Overview:
Parametrised alt-memory bus-cycle controller for the 68000 accelerator board. It synchronises the CPU bus strobes into the CLKOSC domain and decodes the address against a software-programmable 16-region memory map. For alt-memory hits it drives the SDRAM select and generates DTACK after programmable wait states, with a bus-error timeout. It also implements an address-decoded control-register block: map, wait states, speed level, ROM remap and global disable.

Parameters:
SYNC_STAGES, 3, flops in the AS/BGK synchronisers (min 2)
WS_BITS, 3, width of wait-state register
DEFAULT_WS, 2, wait-state reset value
MAP_RST, 16'h0000, reset value of region map (bit n = A[23:20]==n routed to alt memory)
REG_BASE, 20'hFFFE1, A[23:4] match for control registers
TIMEOUT, 255, CLKOSC cycles waiting on MEM_READY before BERR (counter width = clog2(TIMEOUT+1))

Ports:
CLKOSC  in  1  board oscillator clock; all state on rising edge
RST  in  1  asynchronous active-low reset
AS  in  1  CPU address strobe, active-low, asynchronous
RW  in  1  CPU read/write (1 = read)
LDS  in  1  lower data strobe, active-low
A  in  23  CPU address A[23:1]
D  in  8  CPU data D[7:0], valid on writes while LDS low
BGK  in  1  1 = CPU owns bus; 0 = bus granted away
MEM_READY  in  1  SDRAM controller ready for current access
MEM_SEL_N  out  1  active-low alt-memory select to SDRAM controller
DTACK_N  out  1  active-low DTACK to CPU
BERR_N  out  1  active-low bus error to CPU
SPEED  out  2  clock-speed level for clock-switch logic
ROM_REMAP  out  1  1 = alternate ROM decoding active
ENABLE  out  1  1 = alt-memory decoding enabled

Behaviour:
- Reset (RST low, asynchronous): state IDLE; DTACK_N=1, BERR_N=1, MEM_SEL_N=1; MAP=MAP_RST; WS=DEFAULT_WS; SPEED=0; ROM_REMAP=0; ENABLE=1; synchronisers all 1.
- AS and BGK each pass through SYNC_STAGES flops giving AS_S and BGK_S. A, RW, LDS and D are sampled in DECODE only, since they are stable by then.
- Cycle start: AS_S=0 and BGK_S=1.
- Hit classes, computed in DECODE:
  - REG: A[23:4]==REG_BASE.
  - MEM: not REG, ENABLE=1, MAP[A[23:20]]=1 and A[23:20]!=4'hF (region F is never mapped; MAP[15] is ignored).
  - PASS: anything else.
- FSM states: IDLE, DECODE, REG, WAIT, ACK, ERR, PASS.
  - IDLE -> DECODE on cycle start.
  - DECODE -> REG, WAIT or PASS by hit class, one cycle. It also loads the wait counter with WS and clears the timeout counter.
  - REG: applies the register action, then -> ACK.
  - WAIT: the wait counter decrements to 0; then, when MEM_READY=1 -> ACK. The timeout counter increments each WAIT cycle once the wait count reaches 0; reaching TIMEOUT -> ERR.
  - ACK and ERR are held until AS_S=1, then -> IDLE.
  - PASS is held until AS_S=1, then -> IDLE.
- Register actions, by A[3:1]:
  - 0: MAP[7:0]<=D, writes only.
  - 1: MAP[15:8]<=D, writes only.
  - 2: WS<=D[WS_BITS-1:0], writes only.
  - 3: SPEED<=D[1:0], writes only.
  - 6: ENABLE<=0, on any access.
  - 7: ROM_REMAP<=1, on any access.
  - 4 and 5: no action.
  - A write with LDS=1 changes nothing.
  - Every REG access, read or write, is acknowledged.
- Outputs:
  - DTACK_N = ~(state==ACK) | AS.
  - BERR_N = ~(state==ERR) | AS.
  - MEM_SEL_N = ~(state in {WAIT, ACK} and class MEM) | AS.
  - Raw AS gates all three so they negate combinationally when the strobe rises.
- DTACK latency from the DECODE cycle:
  - MEM: 1 + WS cycles + MEM_READY wait.
  - REG: 2 cycles.
- WS=0 means ACK on the first WAIT cycle in which MEM_READY=1.
- BGK_S falling in any state -> IDLE next cycle. All outputs negate; registers are kept.
- AS_S rising before ACK (aborted cycle) -> IDLE. No register action occurs unless REG was already entered.
- Simultaneous action on ENABLE at offset 6 and on MAP: the later access wins. Each takes effect from the next DECODE.
- Back-to-back cycles: IDLE must see AS_S=1 for at least 1 cycle before it accepts the next start.

Test Plan:
- Reset, then AS low at A=0x100000 with MAP=0 -> PASS: MEM_SEL_N, DTACK_N and BERR_N stay 1 through the cycle.
- Write D=0x02 to 0xFFFE10, then access 0x100000 with WS=2 and MEM_READY=1 -> MEM_SEL_N=0; DTACK_N=0 exactly 3 cycles after DECODE; DTACK_N=1 in the same delta as AS rising.
- Write D=0x05 to 0xFFFE14, then a MEM access with MEM_READY held 0 -> BERR_N=0 after 5+TIMEOUT WAIT cycles; DTACK_N stays 1.
- Read 0xFFFE1E, then 0xFFFE1C -> ROM_REMAP=1 and ENABLE=0, each acknowledged with DTACK_N low 2 cycles after DECODE. A subsequent MEM-mapped address gives PASS.
- Write D=0x03 to 0xFFFE16 with LDS=1 -> SPEED stays 0, DTACK still asserted. Repeat with LDS=0 -> SPEED=3.
- BGK dropped during WAIT, and separately RST pulsed during ACK -> outputs return to 1. After BGK drop MAP/WS/SPEED are kept; after RST they take their reset values.

Source files
------------

// File: rtl/altmem_ctrl_68k.sv
// Alt-memory bus-cycle controller for the 68000 accelerator board.
// Synchronises AS/BGK into the CLKOSC domain, decodes each bus cycle against a
// programmable 16-region map, and runs the DTACK/BERR handshake for
// alt-memory hits and for the control-register block at REG_BASE.
module altmem_ctrl_68k #(
    parameter int          SYNC_STAGES = 3,
    parameter int          WS_BITS     = 3,
    parameter int          DEFAULT_WS  = 2,
    parameter logic [15:0] MAP_RST     = 16'h0000,
    parameter logic [19:0] REG_BASE    = 20'hFFFE1,
    parameter int          TIMEOUT     = 255
) (
    input  logic        CLKOSC,
    input  logic        RST,
    input  logic        AS,
    input  logic        RW,
    input  logic        LDS,
    input  logic [23:1] A,
    input  logic [7:0]  D,
    input  logic        BGK,
    input  logic        MEM_READY,
    output logic        MEM_SEL_N,
    output logic        DTACK_N,
    output logic        BERR_N,
    output logic [1:0]  SPEED,
    output logic        ROM_REMAP,
    output logic        ENABLE
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_REG, S_WAIT, S_ACK, S_ERR, S_PASS
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] bgk_sync_q, bgk_sync_d;
    logic                 as_s, bgk_s;
    logic                 arm_q, arm_d;
    logic [WS_BITS-1:0]   wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 class_mem_q, class_mem_d;
    logic [2:0]           idx_q, idx_d;
    logic                 rw_q, rw_d;
    logic                 lds_q, lds_d;
    logic [7:0]           d_q, d_d;

    logic [15:0]          map_q, map_d;
    logic [WS_BITS-1:0]   ws_q, ws_d;
    logic [1:0]           speed_q, speed_d;
    logic                 rom_q, rom_d;
    logic                 en_q, en_d;

    logic                 reg_hit, mem_hit, wait_done;
    logic [3:0]           region;
    logic                 wr_ok, any_ok;

    // Synchroniser chains: stage 0 takes the raw pin, later stages shift.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign as_sync_d[gi]  = AS;
                assign bgk_sync_d[gi] = BGK;
            end else begin : g_rest
                assign as_sync_d[gi]  = as_sync_q[gi-1];
                assign bgk_sync_d[gi] = bgk_sync_q[gi-1];
            end
        end
    endgenerate

    assign as_s  = as_sync_q[SYNC_STAGES-1];
    assign bgk_s = bgk_sync_q[SYNC_STAGES-1];

    // Address classification; only consumed in DECODE when A is stable.
    assign region    = A[23:20];
    assign reg_hit   = (A[23:4] == REG_BASE);
    assign mem_hit   = !reg_hit && en_q && map_q[region] && (region != 4'hF);
    // Last programmed wait state is the cycle in which the count is 1 (or 0 for WS=0).
    assign wait_done = (wait_cnt_q <= WS_BITS'(1));

    // Bus-cycle state, synchronisers and per-cycle latched inputs.
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            as_sync_q   <= '1;
            bgk_sync_q  <= '1;
            arm_q       <= 1'b0;
            wait_cnt_q  <= '0;
            to_cnt_q    <= '0;
            class_mem_q <= 1'b0;
            idx_q       <= '0;
            rw_q        <= 1'b1;
            lds_q       <= 1'b1;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            as_sync_q   <= as_sync_d;
            bgk_sync_q  <= bgk_sync_d;
            arm_q       <= arm_d;
            wait_cnt_q  <= wait_cnt_d;
            to_cnt_q    <= to_cnt_d;
            class_mem_q <= class_mem_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            lds_q       <= lds_d;
            d_q         <= d_d;
        end
    end

    // Next-state logic, wait/timeout counters and DECODE-time input capture.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        to_cnt_d    = to_cnt_q;
        class_mem_d = class_mem_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        lds_d       = lds_q;
        d_d         = d_q;
        // A new cycle is only accepted after IDLE has seen the strobe negated.
        arm_d       = (state_q == S_IDLE) && (arm_q || as_s);

        if (!bgk_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm_q && !as_s) state_d = S_DECODE;
                end
                S_DECODE: begin
                    wait_cnt_d  = ws_q;
                    to_cnt_d    = '0;
                    class_mem_d = mem_hit;
                    idx_d       = A[3:1];
                    rw_d        = RW;
                    lds_d       = LDS;
                    d_d         = D;
                    if (as_s)         state_d = S_IDLE;
                    else if (reg_hit) state_d = S_REG;
                    else if (mem_hit) state_d = S_WAIT;
                    else              state_d = S_PASS;
                end
                S_REG: begin
                    state_d = S_ACK;
                end
                S_WAIT: begin
                    if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - WS_BITS'(1);
                    if (as_s) begin
                        state_d = S_IDLE;
                    end else if (wait_done) begin
                        if (MEM_READY)                       state_d = S_ACK;
                        else if (to_cnt_q == TO_W'(TIMEOUT)) state_d = S_ERR;
                        else                                 to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_ACK, S_ERR, S_PASS: begin
                    if (as_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control-register actions, applied during the single REG cycle.
    always_comb begin
        map_d   = map_q;
        ws_d    = ws_q;
        speed_d = speed_q;
        rom_d   = rom_q;
        en_d    = en_q;
        wr_ok   = !rw_q && !lds_q;
        any_ok  = rw_q || !lds_q;
        if (state_q == S_REG && bgk_s) begin
            case (idx_q)
                3'd0: if (wr_ok)  map_d[7:0]  = d_q;
                3'd1: if (wr_ok)  map_d[15:8] = d_q;
                3'd2: if (wr_ok)  ws_d        = d_q[WS_BITS-1:0];
                3'd3: if (wr_ok)  speed_d     = d_q[1:0];
                3'd6: if (any_ok) en_d        = 1'b0;
                3'd7: if (any_ok) rom_d       = 1'b1;
                default: ;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge CLKOSC or negedge RST) begin
        if (!RST) begin
            map_q   <= MAP_RST;
            ws_q    <= WS_BITS'(DEFAULT_WS);
            speed_q <= 2'd0;
            rom_q   <= 1'b0;
            en_q    <= 1'b1;
        end else begin
            map_q   <= map_d;
            ws_q    <= ws_d;
            speed_q <= speed_d;
            rom_q   <= rom_d;
            en_q    <= en_d;
        end
    end

    // Bus outputs; raw AS gates them so they release as soon as the strobe rises.
    always_comb begin
        DTACK_N   = !(state_q == S_ACK) || AS;
        BERR_N    = !(state_q == S_ERR) || AS;
        MEM_SEL_N = !(((state_q == S_WAIT) || (state_q == S_ACK)) && class_mem_q) || AS;
    end

    assign SPEED     = speed_q;
    assign ROM_REMAP = rom_q;
    assign ENABLE    = en_q;

endmodule

// File: tb/tb_altmem_ctrl_68k.sv
// Directed bench for altmem_ctrl_68k: stimulus pushes the expected outcome of
// each bus cycle into a scoreboard, a monitor records what the DUT presents
// and compares it when the strobe is released.
module tb_altmem_ctrl_68k;

    logic        CLKOSC = 1'b0;
    logic        RST    = 1'b0;
    logic        AS     = 1'b1;
    logic        RW     = 1'b1;
    logic        LDS    = 1'b1;
    logic [23:1] A      = '0;
    logic [7:0]  D      = '0;
    logic        BGK    = 1'b1;
    logic        MEM_READY = 1'b1;
    logic        MEM_SEL_N, DTACK_N, BERR_N;
    logic [1:0]  SPEED;
    logic        ROM_REMAP, ENABLE;

    altmem_ctrl_68k dut (
        .CLKOSC(CLKOSC), .RST(RST), .AS(AS), .RW(RW), .LDS(LDS), .A(A), .D(D),
        .BGK(BGK), .MEM_READY(MEM_READY), .MEM_SEL_N(MEM_SEL_N),
        .DTACK_N(DTACK_N), .BERR_N(BERR_N), .SPEED(SPEED),
        .ROM_REMAP(ROM_REMAP), .ENABLE(ENABLE)
    );

    always #5 CLKOSC = ~CLKOSC;

    // kind: 0 = no response, 1 = DTACK, 2 = BERR; lat = posedges from AS low
    typedef struct {
        int kind; int lat; int sel; int spd; int rom; int en;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int txn    = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // ---------------- monitor ----------------
    logic active = 1'b0;
    int   cyc = 0, lat_seen = 0;
    logic seen_dtack = 0, seen_berr = 0, seen_sel = 0;

    always @(negedge AS) begin
        cyc = 0; lat_seen = 0;
        seen_dtack = 0; seen_berr = 0; seen_sel = 0;
        active = 1'b1;
    end

    always @(posedge CLKOSC) if (active && !AS) cyc++;

    always @(negedge CLKOSC) begin
        if (active) begin
            if (!DTACK_N && !seen_dtack && !seen_berr) begin seen_dtack = 1; lat_seen = cyc; end
            if (!BERR_N && !seen_berr && !seen_dtack) begin seen_berr = 1; lat_seen = cyc; end
            if (!MEM_SEL_N) seen_sel = 1;
        end
    end

    always @(posedge AS) begin
        if (active) begin
            int   kind;
            exp_t e;
            #1;
            txn++;
            check($sformatf("txn%0d_dtack_release", txn), DTACK_N, 1);
            check($sformatf("txn%0d_berr_release", txn), BERR_N, 1);
            check($sformatf("txn%0d_sel_release", txn), MEM_SEL_N, 1);
            kind = seen_berr ? 2 : (seen_dtack ? 1 : 0);
            if (sb.size() == 0) begin
                check($sformatf("txn%0d_unexpected", txn), 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("txn%0d_kind", txn), kind, e.kind);
                if (e.kind != 0) check($sformatf("txn%0d_latency", txn), lat_seen, e.lat);
                check($sformatf("txn%0d_memsel", txn), int'(seen_sel), e.sel);
                check($sformatf("txn%0d_speed", txn), int'(SPEED), e.spd);
                check($sformatf("txn%0d_rom", txn), int'(ROM_REMAP), e.rom);
                check($sformatf("txn%0d_enable", txn), int'(ENABLE), e.en);
            end
            $display("txn %0d: kind=%0d lat=%0d sel=%0d speed=%0d rom=%0d en=%0d",
                     txn, kind, lat_seen, seen_sel, SPEED, ROM_REMAP, ENABLE);
            active = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input int kind, input int lat, input int sel,
                        input int spd, input int rom, input int en);
        exp_t e;
        e.kind = kind; e.lat = lat; e.sel = sel; e.spd = spd; e.rom = rom; e.en = en;
        sb.push_back(e);
    endtask

    task automatic start_cycle(input logic [23:0] addr, input logic rw,
                               input logic lds, input logic [7:0] d);
        @(posedge CLKOSC); #2;
        A = addr[23:1]; RW = rw; LDS = lds; D = d; AS = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (DTACK_N && BERR_N && n < 400) begin
            @(negedge CLKOSC); n++;
        end
    endtask

    task automatic end_cycle();
        @(posedge CLKOSC); #2;
        AS = 1'b1; RW = 1'b1; LDS = 1'b1;
        repeat (5) @(posedge CLKOSC);
    endtask

    task automatic bus(input logic [23:0] addr, input logic rw, input logic lds,
                       input logic [7:0] d, input int kind, input int lat,
                       input int sel, input int spd, input int rom, input int en);
        push(kind, lat, sel, spd, rom, en);
        start_cycle(addr, rw, lds, d);
        if (kind == 0) repeat (12) @(posedge CLKOSC);
        else begin
            wait_resp();
            @(posedge CLKOSC);
        end
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (3) @(posedge CLKOSC);
        #1;
        check("rst_dtack", DTACK_N, 1);
        check("rst_berr", BERR_N, 1);
        check("rst_sel", MEM_SEL_N, 1);
        check("rst_speed", SPEED, 0);
        check("rst_rom", ROM_REMAP, 0);
        check("rst_enable", ENABLE, 1);
        @(posedge CLKOSC); #2; RST = 1'b1;
        repeat (5) @(posedge CLKOSC);

        // unmapped region passes through untouched
        bus(24'h100000, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        // MAP[7:0] = 0x02 maps region 1
        bus(24'hFFFE10, 0, 0, 8'h02, 1, 6, 0, 0, 0, 1);
        // WS=2, ready: DECODE at edge 4, ACK 3 later
        MEM_READY = 1'b1;
        bus(24'h100000, 1, 0, 8'h00, 1, 7, 1, 0, 0, 1);
        // WS=5 then timeout: 4 + 1 + (5 + 255) = 265
        bus(24'hFFFE14, 0, 0, 8'h05, 1, 6, 0, 0, 0, 1);
        MEM_READY = 1'b0;
        bus(24'h100000, 1, 0, 8'h00, 2, 265, 1, 0, 0, 1);
        // SPEED write with LDS high changes nothing but is acked
        bus(24'hFFFE16, 0, 1, 8'h03, 1, 6, 0, 0, 0, 1);
        bus(24'hFFFE16, 0, 0, 8'h03, 1, 6, 0, 3, 0, 1);

        // BGK taken away during WAIT
        push(0, 0, 1, 3, 0, 1);
        start_cycle(24'h100000, 1, 0, 8'h00);
        repeat (6) @(posedge CLKOSC); #2; BGK = 1'b0;
        repeat (6) @(posedge CLKOSC);
        @(negedge CLKOSC);
        check("bgk_dtack", DTACK_N, 1);
        check("bgk_berr", BERR_N, 1);
        check("bgk_sel", MEM_SEL_N, 1);
        @(posedge CLKOSC); #2; BGK = 1'b1;
        end_cycle();
        repeat (3) @(posedge CLKOSC);

        // WS=0: ACK straight after the first WAIT cycle; MAP kept across BGK drop
        MEM_READY = 1'b1;
        bus(24'hFFFE14, 0, 0, 8'h00, 1, 6, 0, 3, 0, 1);
        bus(24'h100000, 1, 0, 8'h00, 1, 6, 1, 3, 0, 1);
        // MAP[15:8] = 0xFF: region E maps, region F never does
        bus(24'hFFFE12, 0, 0, 8'hFF, 1, 6, 0, 3, 0, 1);
        bus(24'hE00000, 1, 0, 8'h00, 1, 6, 1, 3, 0, 1);
        bus(24'hF00000, 1, 0, 8'h00, 0, 0, 0, 3, 0, 1);
        // ROM remap and disable via reads
        bus(24'hFFFE1E, 1, 0, 8'h00, 1, 6, 0, 3, 1, 1);
        bus(24'hFFFE1C, 1, 0, 8'h00, 1, 6, 0, 3, 1, 0);
        bus(24'h100000, 1, 0, 8'h00, 0, 0, 0, 3, 1, 0);

        // RST pulsed while ACK is asserted
        push(1, 6, 0, 0, 0, 1);
        start_cycle(24'hFFFE18, 1, 0, 8'h00);
        wait_resp();
        #1; RST = 1'b0; #1;
        check("rst2_dtack", DTACK_N, 1);
        check("rst2_berr", BERR_N, 1);
        check("rst2_sel", MEM_SEL_N, 1);
        check("rst2_speed", SPEED, 0);
        check("rst2_rom", ROM_REMAP, 0);
        check("rst2_enable", ENABLE, 1);
        AS = 1'b1;
        repeat (2) @(posedge CLKOSC); #2; RST = 1'b1;
        repeat (5) @(posedge CLKOSC);

        // aborted REG write: strobe gone before REG, SPEED must stay 0
        push(0, 0, 0, 0, 0, 1);
        start_cycle(24'hFFFE16, 0, 0, 8'h01);
        @(posedge CLKOSC); #2; AS = 1'b1; RW = 1'b1; LDS = 1'b1;
        repeat (8) @(posedge CLKOSC);
        @(negedge CLKOSC);
        check("abort_speed", SPEED, 0);

        // MAP and WS back at reset values
        bus(24'h100000, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        bus(24'hFFFE10, 0, 0, 8'h02, 1, 6, 0, 0, 0, 1);
        bus(24'h100000, 1, 0, 8'h00, 1, 7, 1, 0, 0, 1);

        repeat (5) @(posedge CLKOSC);
        check("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
